// File: rtl/width_shrink_buffer.sv
// Width-down converter: queues IN_WIDTH-bit words in a small FIFO and emits them
// as OUT_WIDTH-bit beats (LS beat first), with cycle counters for throughput analysis.
module width_shrink_buffer #(
  parameter int IN_WIDTH        = 64,
  parameter int OUT_WIDTH       = 32,
  parameter int QUEUE_ADDR_BITS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IN_WIDTH-1:0]  d_a,
  input  logic                 vld_a,
  output logic                 rdy_a,
  output logic [OUT_WIDTH-1:0] d_b,
  output logic                 vld_b,
  input  logic                 rdy_b,
  input  logic                 is_done_mode_user,
  output logic [31:0]          full_cnt,
  output logic [31:0]          empty_cnt,
  output logic [31:0]          read_cnt,
  output logic                 stall_condition
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int DEPTH = 2 ** QUEUE_ADDR_BITS;
  localparam logic [QUEUE_ADDR_BITS:0] DEPTH_CNT = (QUEUE_ADDR_BITS + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]         LAST_IDX  = IDX_W'(RATIO - 1);

  typedef enum logic {IDLE, SEND} state_t;

  logic [IN_WIDTH-1:0]        mem [DEPTH];
  logic [QUEUE_ADDR_BITS-1:0] wr_ptr, rd_ptr;
  logic [QUEUE_ADDR_BITS:0]   count;
  logic                       q_full, q_empty, push, pop;

  state_t                     state, state_next;
  logic [IN_WIDTH-1:0]        shift_reg, shift_next;
  logic [IDX_W-1:0]           beat_idx, idx_next;
  logic                       vld_b_q, vld_next;
  logic                       beat_accept;

  assign q_full  = (count == DEPTH_CNT);
  assign q_empty = (count == '0);
  // Ready depends on occupancy only, so a full queue refuses a write even when popping.
  assign rdy_a   = !reset && !q_full;
  assign push    = vld_a && rdy_a;

  assign d_b             = shift_reg[OUT_WIDTH-1:0];
  assign vld_b           = vld_b_q;
  assign beat_accept     = vld_b_q && rdy_b;
  assign stall_condition = vld_b_q && !rdy_b;

  // NOTE: queue storage has no reset; count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= d_a;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      beat_idx  <= '0;
      vld_b_q   <= 1'b0;
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      beat_idx  <= idx_next;
      vld_b_q   <= vld_next;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    shift_next = shift_reg;
    idx_next   = beat_idx;
    vld_next   = vld_b_q;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!q_empty) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr];
          idx_next   = '0;
          vld_next   = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (beat_accept) begin
          if (beat_idx != LAST_IDX) begin
            shift_next = shift_reg >> OUT_WIDTH;
            idx_next   = beat_idx + IDX_W'(1);
          end else if (!q_empty) begin
            // Reload on the last beat so consecutive words stream without a bubble.
            pop        = 1'b1;
            shift_next = mem[rd_ptr];
            idx_next   = '0;
          end else begin
            vld_next   = 1'b0;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_cnt  <= '0;
      empty_cnt <= '0;
      read_cnt  <= '0;
    end else if (!is_done_mode_user) begin
      if (q_full)                    full_cnt  <= full_cnt + 32'd1;
      if (q_empty && state == IDLE)  empty_cnt <= empty_cnt + 32'd1;
      if (beat_accept)               read_cnt  <= read_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_width_shrink_buffer.sv
// Scoreboard bench for width_shrink_buffer: stimulus pushes expected beats on word
// acceptance, an independent monitor pops and compares on every accepted output beat.
module tb_width_shrink_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] d_a;
  logic        vld_a;
  logic        rdy_a;
  logic [31:0] d_b;
  logic        vld_b;
  logic        rdy_b;
  logic        is_done_mode_user;
  logic [31:0] full_cnt, empty_cnt, read_cnt;
  logic        stall_condition;

  width_shrink_buffer #(.IN_WIDTH(64), .OUT_WIDTH(32), .QUEUE_ADDR_BITS(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .d_a               (d_a),
    .vld_a             (vld_a),
    .rdy_a             (rdy_a),
    .d_b               (d_b),
    .vld_b             (vld_b),
    .rdy_b             (rdy_b),
    .is_done_mode_user (is_done_mode_user),
    .full_cnt          (full_cnt),
    .empty_cnt         (empty_cnt),
    .read_cnt          (read_cnt),
    .stall_condition   (stall_condition)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_beat = '0, prev_beat = '0;
  bit          track_gap = 1'b0, seen_first = 1'b0;
  int          gap_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [63:0] d);
    exp_q.push_back(d[31:0]);
    exp_q.push_back(d[63:32]);
  endtask

  // Monitor: compares every accepted beat against the scoreboard head.
  always @(negedge clk) begin
    if (!reset) begin
      if (vld_b && rdy_b) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          check("beat_data", d_b, exp_q.pop_front());
          prev_beat = last_beat;
          last_beat = d_b;
        end
      end
      if (track_gap) begin
        if (vld_b) seen_first = 1'b1;
        else if (seen_first && exp_q.size() != 0) gap_cnt++;
      end
    end
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic try_word(input logic [63:0] d, output bit acc);
    d_a   = d;
    vld_a = 1'b1;
    @(negedge clk);
    acc = rdy_a;
    if (acc) push_word(d);
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [63:0] d);
    bit acc = 1'b0;
    for (int n = 0; n < 200 && !acc; n++) try_word(d, acc);
    check("send_accepted", acc, 1);
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 20000 && exp_q.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    check("drain_complete", exp_q.size(), 0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("rdy_a_in_reset", rdy_a, 0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Queue empty, FSM idle, rdy_b=1: word accepted in cycle 0 shows beats in cycles 2 and 3.
  task automatic single_word_latency(input logic [63:0] d);
    d_a   = d;
    vld_a = 1'b1;
    @(negedge clk);
    check("lat_rdy_a", rdy_a, 1);
    push_word(d);
    @(posedge clk); #1;
    vld_a = 1'b0;
    @(negedge clk);
    check("lat_c1_vld_b", vld_b, 0);
    @(negedge clk);
    check("lat_c2_vld_b", vld_b, 1);
    check("lat_c2_d_b", d_b, d[31:0]);
    @(negedge clk);
    check("lat_c3_vld_b", vld_b, 1);
    check("lat_c3_d_b", d_b, d[63:32]);
    @(negedge clk);
    check("lat_c4_vld_b", vld_b, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc;
    int          j;
    logic [31:0] f0, f1, r0, e0;

    reset = 1'b1;
    vld_a = 1'b0;
    d_a   = '0;
    rdy_b = 1'b0;
    is_done_mode_user = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset_rdy_a", rdy_a, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_vld_b", vld_b, 0);
    check("reset_d_b", d_b, 0);
    check("reset_full_cnt", full_cnt, 0);
    check("reset_empty_cnt", empty_cnt, 0);
    check("reset_read_cnt", read_cnt, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_rdy_a", rdy_a, 1);
    check("post_reset_empty_cnt", empty_cnt, 0);
    repeat (3) @(negedge clk);
    check("empty_cnt_idle_3", empty_cnt, 3);
    @(posedge clk); #1;

    // Single word with exact latency
    rdy_b = 1'b1;
    single_word_latency(64'h0000_0002_0000_0001);
    check("single_read_cnt", read_cnt, 2);

    // Streaming 2000 words
    apply_reset();
    track_gap  = 1'b1;
    seen_first = 1'b0;
    for (int i = 0; i < 2000; i++) send_word(64'(i));
    vld_a = 1'b0;
    wait_drain();
    track_gap = 1'b0;
    check("stream_no_gap", gap_cnt, 0);
    check("stream_read_cnt", read_cnt, 4000);
    check("stream_prev_beat", prev_beat, 32'd1999);
    check("stream_last_beat", last_beat, 32'd0);

    // Fill with rdy_b=0, then drain
    rdy_b = 1'b0;
    j = 0;
    for (int c = 0; c < 10; c++) begin
      try_word({32'(201 + 2 * j), 32'(200 + 2 * j)}, acc);
      if (acc) j++;
    end
    check("fill_accepted_words", j, 5);
    @(negedge clk);
    check("fill_rdy_a", rdy_a, 0);
    check("fill_stall", stall_condition, 1);
    f0 = full_cnt;
    @(negedge clk);
    f1 = full_cnt;
    check("fill_full_cnt_step", f1 - f0, 1);
    @(posedge clk); #1;
    vld_a = 1'b0;
    r0 = read_cnt;
    rdy_b = 1'b1;
    wait_drain();
    check("drain_read_cnt_delta", read_cnt - r0, 10);

    // Mid-word backpressure: rdy_b 1,0,0,1
    rdy_b = 1'b0;
    send_word({32'hBBBB_0002, 32'hAAAA_0001});
    vld_a = 1'b0;
    for (int n = 0; n < 10 && !vld_b; n++) begin
      @(posedge clk); #1;
    end
    check("bp_vld_b_up", vld_b, 1);
    rdy_b = 1'b1;
    @(negedge clk);
    check("bp_beat0", d_b, 32'hAAAA_0001);
    @(posedge clk); #1;
    rdy_b = 1'b0;
    @(negedge clk);
    check("bp_hold1", d_b, 32'hBBBB_0002);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_hold2", d_b, 32'hBBBB_0002);
    @(posedge clk); #1;
    rdy_b = 1'b1;
    @(negedge clk);
    check("bp_hold3", d_b, 32'hBBBB_0002);
    check("bp_hold3_vld", vld_b, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_done_vld", vld_b, 0);
    check("bp_scoreboard_empty", exp_q.size(), 0);
    @(posedge clk); #1;

    // Reset mid-operation: beat 0 pending, 3 words queued
    rdy_b = 1'b0;
    for (int i = 0; i < 4; i++) send_word({32'(16'hC000 + 2 * i + 1), 32'(16'hC000 + 2 * i)});
    vld_a = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("mid_vld_b_pending", vld_b, 1);
    check("mid_rdy_a_not_full", rdy_a, 1);
    apply_reset();
    @(negedge clk);
    check("mid_after_vld_b", vld_b, 0);
    check("mid_after_d_b", d_b, 0);
    check("mid_after_read_cnt", read_cnt, 0);
    check("mid_after_full_cnt", full_cnt, 0);
    @(posedge clk); #1;
    rdy_b = 1'b1;
    single_word_latency(64'h1234_5678_9ABC_DEF0);
    check("mid_restart_read_cnt", read_cnt, 2);

    // Counter freeze during traffic
    is_done_mode_user = 1'b1;
    @(negedge clk);
    f0 = full_cnt;
    e0 = empty_cnt;
    r0 = read_cnt;
    @(posedge clk); #1;
    rdy_b = 1'b0;
    for (int i = 0; i < 5; i++) send_word({32'(16'hF000 + 2 * i + 1), 32'(16'hF000 + 2 * i)});
    vld_a = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rdy_b = 1'b1;
    wait_drain();
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("freeze_full_cnt", full_cnt, f0);
    check("freeze_empty_cnt", empty_cnt, e0);
    check("freeze_read_cnt", read_cnt, r0);
    is_done_mode_user = 1'b0;
    single_word_latency(64'h0BAD_CAFE_0D15_EA5E);
    check("unfreeze_read_cnt", read_cnt, r0 + 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
